// File: rtl/lifo_stack_arbiter_2port.sv
// Two-port round-robin arbiter and sequencer for the shared LIFO stack.
// Each transaction takes three cycles: IDLE (grant), ISSUE (strobe) and RESP (ack).
// Every output is driven straight from a flop.
module lifo_stack_arbiter_2port #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Req0_In,
  input  logic                  Req1_In,
  input  logic [1:0]            Op0_In,
  input  logic [1:0]            Op1_In,
  input  logic [DATA_WIDTH-1:0] Data0_In,
  input  logic [DATA_WIDTH-1:0] Data1_In,
  output logic                  Ack0_Out,
  output logic                  Ack1_Out,
  output logic                  Err0_Out,
  output logic                  Err1_Out,
  output logic [DATA_WIDTH-1:0] Data0_Out,
  output logic [DATA_WIDTH-1:0] Data1_Out,
  output logic                  Busy_Out,
  output logic                  Stack_Push_Out,
  output logic                  Stack_Pop_Out,
  output logic                  Stack_Peek_Out,
  output logic [DATA_WIDTH-1:0] Stack_Data_Out,
  input  logic [DATA_WIDTH-1:0] Stack_Data_In,
  input  logic                  Stack_Empty_In,
  input  logic                  Stack_Full_In
);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                  state_reg, state_next;
  logic                    grant_port;
  logic                    last_grant_reg;
  logic                    gnt_reg;
  logic [1:0]              op_reg;
  logic                    rej_reg;
  logic                    busy_reg;
  logic                    push_reg, pop_reg, peek_reg;
  logic [DATA_WIDTH-1:0]   stack_data_reg;
  logic [1:0]              sel_op;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    illegal;
  logic                    take_grant;
  logic [1:0]              ack_vec;
  logic [1:0]              err_vec;
  logic [DATA_WIDTH-1:0]   data_vec [2];

  // The granted port's operation, its data, and whether the stack can accept that operation right now
  assign sel_op   = grant_port ? Op1_In : Op0_In;
  assign sel_data = grant_port ? Data1_In : Data0_In;
  assign illegal  = (sel_op == OP_ILL) ||
                    ((sel_op == OP_PUSH) && Stack_Full_In) ||
                    (((sel_op == OP_POP) || (sel_op == OP_PEEK)) && Stack_Empty_In);
  assign take_grant = (state_reg == IDLE) && (state_next == ISSUE);

  // State register
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic and round-robin grant choice (loser of the last contest wins a tie)
  always_comb begin
    state_next = state_reg;
    grant_port = Req1_In;
    if (Req0_In && Req1_In) grant_port = ~last_grant_reg;
    case (state_reg)
      IDLE:    if (Req0_In || Req1_In) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant capture and the one-cycle stack command issued during ISSUE
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      last_grant_reg <= 1'b1;
      gnt_reg        <= 1'b0;
      op_reg         <= OP_PUSH;
      rej_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      push_reg       <= 1'b0;
      pop_reg        <= 1'b0;
      peek_reg       <= 1'b0;
      stack_data_reg <= '0;
    end else begin
      busy_reg       <= (state_next != IDLE);
      push_reg       <= 1'b0;
      pop_reg        <= 1'b0;
      peek_reg       <= 1'b0;
      stack_data_reg <= '0;
      if (take_grant) begin
        gnt_reg        <= grant_port;
        last_grant_reg <= grant_port;
        op_reg         <= sel_op;
        rej_reg        <= illegal;
        push_reg       <= !illegal && (sel_op == OP_PUSH);
        pop_reg        <= !illegal && (sel_op == OP_POP);
        peek_reg       <= !illegal && (sel_op == OP_PEEK);
        stack_data_reg <= (sel_op == OP_PUSH) ? sel_data : '0;
      end
    end
  end

  // Per-port response registers: loaded at the end of ISSUE, cleared after one cycle
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic                  ack_reg;
      logic                  err_reg;
      logic [DATA_WIDTH-1:0] data_reg;

      // Ack/err/data pulse only for the port that owns the current transaction
      always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
          ack_reg  <= 1'b0;
          err_reg  <= 1'b0;
          data_reg <= '0;
        end else if ((state_reg == ISSUE) && (gnt_reg == 1'(gi))) begin
          ack_reg  <= 1'b1;
          err_reg  <= rej_reg;
          data_reg <= (!rej_reg && (op_reg != OP_PUSH)) ? Stack_Data_In : '0;
        end else begin
          ack_reg  <= 1'b0;
          err_reg  <= 1'b0;
          data_reg <= '0;
        end
      end

      assign ack_vec[gi]  = ack_reg;
      assign err_vec[gi]  = err_reg;
      assign data_vec[gi] = data_reg;
    end
  endgenerate

  assign Ack0_Out       = ack_vec[0];
  assign Ack1_Out       = ack_vec[1];
  assign Err0_Out       = err_vec[0];
  assign Err1_Out       = err_vec[1];
  assign Data0_Out      = data_vec[0];
  assign Data1_Out      = data_vec[1];
  assign Busy_Out       = busy_reg;
  assign Stack_Push_Out = push_reg;
  assign Stack_Pop_Out  = pop_reg;
  assign Stack_Peek_Out = peek_reg;
  assign Stack_Data_Out = stack_data_reg;

endmodule
